// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/bus controller.
// Holds the data and inst bus FSM encodings and the counter widths.
package pipe_ctrl_pkg;

    localparam int STALL_CNT_W = 32;
    localparam int FLUSH_CNT_W = 16;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_CNT_MAX = {FLUSH_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        D_IDLE      = 2'd0,
        D_WAIT_ADDR = 2'd1,
        D_WAIT_DATA = 2'd2
    } data_state_t;

    typedef enum logic [1:0] {
        I_IDLE    = 2'd0,
        I_WAIT    = 2'd1,
        I_DISCARD = 2'd2
    } inst_state_t;

endpackage

// File: rtl/pipe_bus_fsm.sv
// Generic req/addr_ok/data_ok bus transaction tracker (idle, address phase,
// data phase). A new request is refused while abort is high in idle.
module pipe_bus_fsm
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic       abort,
    input  logic       addr_ok,
    input  logic       data_ok,
    output logic       bus_req,
    output logic       busy,
    output logic [1:0] state
);

    data_state_t state_r;
    data_state_t state_nxt_s;
    logic        issue_s;
    logic        bus_req_s;
    logic        busy_s;

    // Transaction phase register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= D_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next phase and request/busy decode; the request is never reissued in data phase
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        bus_req_s   = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            D_IDLE: begin
                issue_s   = req & ~abort;
                bus_req_s = issue_s;
                busy_s    = issue_s;
                if (issue_s) begin
                    state_nxt_s = addr_ok ? D_WAIT_DATA : D_WAIT_ADDR;
                end else begin
                    state_nxt_s = D_IDLE;
                end
            end
            D_WAIT_ADDR: begin
                bus_req_s = 1'b1;
                busy_s    = 1'b1;
                if (addr_ok) begin
                    state_nxt_s = D_WAIT_DATA;
                end else begin
                    state_nxt_s = D_WAIT_ADDR;
                end
            end
            D_WAIT_DATA: begin
                busy_s = ~data_ok;
                if (data_ok) begin
                    state_nxt_s = D_IDLE;
                end else begin
                    state_nxt_s = D_WAIT_DATA;
                end
            end
            default: begin
                state_nxt_s = D_IDLE;
            end
        endcase
    end

    assign bus_req = bus_req_s;
    assign busy    = busy_s;
    assign state   = state_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/refresh controller with data and inst bus tracking.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ex_data_req,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic                   if_fetch,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic                   div_busy,
    input  logic                   load_use,
    input  logic                   exc_flush,
    output logic                   if_id_stall,
    output logic                   if_id_refresh,
    output logic                   id_ex_stall,
    output logic                   id_ex_refresh,
    output logic                   ex_wb_stall,
    output logic                   ex_wb_refresh,
    output logic                   data_req_o,
    output logic                   inst_kill,
    output logic                   flush_pending_o,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);

    logic [1:0]  d_state_s;
    logic        data_busy_s;
    logic        d_idle_s;
    logic        d_wait_data_s;
    logic        deferred_fire_s;
    logic        flush_s;
    logic        flush_pending_r;
    inst_state_t i_state_r;
    inst_state_t i_state_nxt_s;
    logic        inst_kill_s;
    logic        inst_busy_s;
    logic        ex_wb_stall_s;
    logic        if_id_stall_s;

    pipe_bus_fsm u_data_fsm (
        .clk     (clk),
        .resetn  (resetn),
        .req     (ex_data_req),
        .abort   (exc_flush),
        .addr_ok (data_addr_ok),
        .data_ok (data_data_ok),
        .bus_req (data_req_o),
        .busy    (data_busy_s),
        .state   (d_state_s)
    );

    assign d_idle_s        = (d_state_s == D_IDLE);
    assign d_wait_data_s   = (d_state_s == D_WAIT_DATA);
    // A flush raised mid-transaction waits for the data beat to land
    assign deferred_fire_s = flush_pending_r & d_wait_data_s & data_data_ok;
    assign flush_s         = (exc_flush & d_idle_s) | deferred_fire_s;

    // Deferred-flush flag: set by a flush during an open data transaction
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_pending_r <= 1'b0;
        end else if (deferred_fire_s) begin
            flush_pending_r <= 1'b0;
        end else if (exc_flush & ~d_idle_s) begin
            flush_pending_r <= 1'b1;
        end else begin
            flush_pending_r <= flush_pending_r;
        end
    end

    // Inst fetch state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_state_r <= I_IDLE;
        end else begin
            i_state_r <= i_state_nxt_s;
        end
    end

    // Inst fetch next state; a flushed fetch still owes a response that is killed
    always_comb begin
        i_state_nxt_s = i_state_r;
        inst_kill_s   = 1'b0;
        inst_busy_s   = 1'b0;
        case (i_state_r)
            I_IDLE: begin
                inst_busy_s = if_fetch & ~inst_addr_ok;
                if (if_fetch & inst_addr_ok) begin
                    i_state_nxt_s = I_WAIT;
                end else begin
                    i_state_nxt_s = I_IDLE;
                end
            end
            I_WAIT: begin
                inst_busy_s = ~inst_data_ok;
                inst_kill_s = flush_s & inst_data_ok;
                if (inst_data_ok) begin
                    i_state_nxt_s = I_IDLE;
                end else if (flush_s) begin
                    i_state_nxt_s = I_DISCARD;
                end else begin
                    i_state_nxt_s = I_WAIT;
                end
            end
            I_DISCARD: begin
                inst_busy_s = 1'b1;
                inst_kill_s = inst_data_ok;
                if (inst_data_ok) begin
                    i_state_nxt_s = I_IDLE;
                end else begin
                    i_state_nxt_s = I_DISCARD;
                end
            end
            default: begin
                i_state_nxt_s = I_IDLE;
            end
        endcase
    end

    assign ex_wb_stall_s   = data_busy_s | div_busy;
    assign if_id_stall_s   = ex_wb_stall_s | load_use | inst_busy_s;

    assign ex_wb_stall     = ex_wb_stall_s;
    assign id_ex_stall     = ex_wb_stall_s;
    assign if_id_stall     = if_id_stall_s;
    assign if_id_refresh   = flush_s;
    assign id_ex_refresh   = flush_s | (load_use & ~ex_wb_stall_s);
    assign ex_wb_refresh   = flush_s;
    assign inst_kill       = inst_kill_s;
    assign flush_pending_o = flush_pending_r;

`ifdef PIPE_CTRL_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    logic [FLUSH_CNT_W-1:0] flush_cnt_r;

    // Saturating stall and flush event counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
            flush_cnt_r <= {FLUSH_CNT_W{1'b0}};
        end else begin
            if (if_id_stall_s && (stall_cnt_r != STALL_CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_s && (flush_cnt_r != FLUSH_CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {STALL_CNT_W{1'b0}};
    assign flush_cnt = {FLUSH_CNT_W{1'b0}};
`endif

endmodule
